// File: rtl/local_bus_ctrl_if.sv
// 68030 local-bus signal bundle between the CPU side and the termination controller.
interface local_bus_ctrl_if #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned DATA_W = 8
);
    logic                    AS20;
    logic                    RW20;
    logic [1:0]              A32;
    logic                    CBREQ;
    logic [NCH-1:0]          ACCESS;
    logic [NCH*DATA_W-1:0]   CH_DOUT;
    logic                    STERM;
    logic                    CBACK;
    logic                    CIIN;
    logic                    INTCYCLE;
    logic [NCH-1:0]          CH_SEL;
    logic [1:0]              BEAT;
    logic [DATA_W-1:0]       D_OUT;
    logic                    D_OE;

    // CPU / slave-decode side: drives strobes, decodes and slave data.
    modport master (
        output AS20, RW20, A32, CBREQ, ACCESS, CH_DOUT,
        input  STERM, CBACK, CIIN, INTCYCLE, CH_SEL, BEAT, D_OUT, D_OE
    );

    // Termination controller side.
    modport slave (
        input  AS20, RW20, A32, CBREQ, ACCESS, CH_DOUT,
        output STERM, CBACK, CIIN, INTCYCLE, CH_SEL, BEAT, D_OUT, D_OE
    );
endinterface

// File: rtl/local_bus_ctrl.sv
// Termination and steering controller for the 68030 local bus.
// Grants the lowest-index internal slave whose ACCESS decode is low, inserts
// per-channel wait states, issues STERM/CIIN/INTCYCLE and muxes read data.
// Optional cache-line burst support (CBREQ/CBACK, 4-beat wrap) is built when
// the macro LBC_BURST_EN is defined; otherwise CBACK is tied high.
module local_bus_ctrl #(
    parameter int unsigned           NCH        = 4,
    parameter int unsigned           DATA_W     = 8,
    parameter int unsigned           WS_W       = 3,
    parameter logic [NCH*WS_W-1:0]   WS_INIT    = {3'd1, 3'd2, 3'd1, 3'd0},
    parameter int unsigned           BURST_WS   = 0,
    parameter logic [NCH-1:0]        BURST_MASK = 4'b0001,
    parameter logic [NCH-1:0]        CACHE_MASK = 4'b0001
) (
    input  logic            CLKCPU,
    input  logic            RESET,
    local_bus_ctrl_if.slave bus
);
    localparam int unsigned GNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CNT_W = (WS_W > 3) ? WS_W : 3;

`ifdef LBC_BURST_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_TERM, S_DONE, S_BWAIT, S_BTERM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM, S_DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [GNT_W-1:0]    gnt_q, gnt_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic                sterm_q, sterm_d;
    logic                ciin_q, ciin_d;
    logic                intcycle_q, intcycle_d;
    logic                d_oe_q, d_oe_d;
    logic [NCH-1:0]      ch_sel_q, ch_sel_d;
    logic [1:0]          beat_q, beat_d;
    logic [DATA_W-1:0]   d_out_q, d_out_d;
`ifdef LBC_BURST_EN
    logic                cback_q, cback_d;
    logic [1:0]          bcnt_q, bcnt_d;
`endif

    logic [WS_W-1:0]     ws_tab   [NCH];
    logic [DATA_W-1:0]   dout_tab [NCH];
    logic                arb_hit_c;
    logic [GNT_W-1:0]    arb_idx_c;

    // Unpack per-channel wait states and read data.
    for (genvar i = 0; i < NCH; i++) begin : g_tab
        assign ws_tab[i]   = WS_INIT[i*WS_W +: WS_W];
        assign dout_tab[i] = bus.CH_DOUT[i*DATA_W +: DATA_W];
    end

    // Fixed priority: lowest-index active-low decode wins.
    always_comb begin
        arb_hit_c = 1'b0;
        arb_idx_c = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!bus.ACCESS[i]) begin
                arb_hit_c = 1'b1;
                arb_idx_c = GNT_W'(i);
            end
        end
    end

    // Next state and next registered outputs; AS20 high outside IDLE aborts.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        wcnt_d     = wcnt_q;
        sterm_d    = 1'b1;
        ciin_d     = ciin_q;
        intcycle_d = intcycle_q;
        d_oe_d     = d_oe_q;
        ch_sel_d   = ch_sel_q;
        beat_d     = beat_q;
        d_out_d    = d_out_q;
`ifdef LBC_BURST_EN
        cback_d    = cback_q;
        bcnt_d     = bcnt_q;
`endif
        if ((state_q != S_IDLE) && bus.AS20) begin
            state_d    = S_IDLE;
            ciin_d     = 1'b1;
            intcycle_d = 1'b1;
            d_oe_d     = 1'b0;
            ch_sel_d   = '1;
            beat_d     = 2'd0;
            d_out_d    = '0;
`ifdef LBC_BURST_EN
            cback_d    = 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.AS20 && arb_hit_c) begin
                        gnt_d      = arb_idx_c;
                        ch_sel_d   = ~(NCH'(1) << arb_idx_c);
                        intcycle_d = 1'b0;
                        beat_d     = bus.A32;
                        ciin_d     = CACHE_MASK[arb_idx_c];
                        d_oe_d     = bus.RW20;
                        wcnt_d     = CNT_W'(ws_tab[arb_idx_c]);
                        state_d    = (ws_tab[arb_idx_c] != '0) ? S_WAIT : S_TERM;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q <= CNT_W'(1)) begin
                        state_d = S_TERM;
                    end else begin
                        wcnt_d = wcnt_q - CNT_W'(1);
                    end
                end
                S_TERM: begin
                    sterm_d = 1'b0;
                    d_out_d = dout_tab[gnt_q];
                    state_d = S_DONE;
`ifdef LBC_BURST_EN
                    if (BURST_MASK[gnt_q] && !bus.CBREQ) begin
                        cback_d = 1'b0;
                        bcnt_d  = 2'd0;
                        wcnt_d  = CNT_W'(BURST_WS);
                        state_d = (BURST_WS == 0) ? S_BTERM : S_BWAIT;
                    end
`endif
                end
`ifdef LBC_BURST_EN
                S_BWAIT: begin
                    if (wcnt_q <= CNT_W'(1)) begin
                        state_d = S_BTERM;
                    end else begin
                        wcnt_d = wcnt_q - CNT_W'(1);
                    end
                end
                S_BTERM: begin
                    sterm_d = 1'b0;
                    d_out_d = dout_tab[gnt_q];
                    beat_d  = beat_q + 2'd1;
                    if (bcnt_q == 2'd2) begin
                        // Fourth beat: release CBACK together with the last STERM.
                        cback_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        bcnt_d  = bcnt_q + 2'd1;
                        wcnt_d  = CNT_W'(BURST_WS);
                        state_d = (BURST_WS == 0) ? S_BTERM : S_BWAIT;
                    end
                end
`endif
                S_DONE: begin
                    d_oe_d = 1'b0;
`ifdef LBC_BURST_EN
                    cback_d = 1'b1;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            wcnt_q     <= '0;
            sterm_q    <= 1'b1;
            ciin_q     <= 1'b1;
            intcycle_q <= 1'b1;
            d_oe_q     <= 1'b0;
            ch_sel_q   <= '1;
            beat_q     <= 2'd0;
            d_out_q    <= '0;
`ifdef LBC_BURST_EN
            cback_q    <= 1'b1;
            bcnt_q     <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            wcnt_q     <= wcnt_d;
            sterm_q    <= sterm_d;
            ciin_q     <= ciin_d;
            intcycle_q <= intcycle_d;
            d_oe_q     <= d_oe_d;
            ch_sel_q   <= ch_sel_d;
            beat_q     <= beat_d;
            d_out_q    <= d_out_d;
`ifdef LBC_BURST_EN
            cback_q    <= cback_d;
            bcnt_q     <= bcnt_d;
`endif
        end
    end

    assign bus.STERM    = sterm_q;
    assign bus.CIIN     = ciin_q;
    assign bus.INTCYCLE = intcycle_q;
    assign bus.D_OE     = d_oe_q;
    assign bus.CH_SEL   = ch_sel_q;
    assign bus.BEAT     = beat_q;
    assign bus.D_OUT    = d_out_q;

`ifdef LBC_BURST_EN
    assign bus.CBACK    = cback_q;
`else
    // Without burst support CBACK never asserts and burst inputs are don't-care.
    assign bus.CBACK    = 1'b1;
    logic unused_c;
    assign unused_c = ^{bus.CBREQ, BURST_MASK, 32'(BURST_WS)};
`endif

endmodule
